// File: rtl/iq_pkg.sv
// Shared types and helpers for the IQ modulator/demodulator LO path.
package iq_pkg;

    localparam int DATA_W_DEFAULT = 5;

    localparam logic signed [1:0] LO_POS  = 2'sb01;
    localparam logic signed [1:0] LO_ZERO = 2'sb00;
    localparam logic signed [1:0] LO_NEG  = 2'sb11;

    typedef enum logic [1:0] {
        PH_0   = 2'd0,
        PH_90  = 2'd1,
        PH_180 = 2'd2,
        PH_270 = 2'd3
    } lo_phase_t;

    function automatic logic signed [1:0] lo_cos(input lo_phase_t p);
        case (p)
            PH_0:    return LO_POS;
            PH_180:  return LO_NEG;
            default: return LO_ZERO;
        endcase
    endfunction

    function automatic logic signed [1:0] lo_sin(input lo_phase_t p);
        case (p)
            PH_90:   return LO_POS;
            PH_270:  return LO_NEG;
            default: return LO_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/lo_phase_gen.sv
// Four-phase fs/4 quadrature LO. The phase presented on "phase"/cos/sin is
// the one to apply to a sample accepted this cycle: a sync request forces
// PH_0 immediately so the synced sample itself is rotated with PH_0.
//
// state  | meaning
// PH_0   | cos=+1, sin= 0
// PH_90  | cos= 0, sin=+1
// PH_180 | cos=-1, sin= 0
// PH_270 | cos= 0, sin=-1
module lo_phase_gen
    import iq_pkg::*;
#(
    parameter bit PHASE_DIR = 1'b0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              advance,
    input  logic              sync,
    output lo_phase_t         phase,
    output logic signed [1:0] cos_val,
    output logic signed [1:0] sin_val
);

    lo_phase_t state;

    function automatic lo_phase_t step(input lo_phase_t p);
        if (PHASE_DIR)
            return lo_phase_t'(p - 2'd1);
        else
            return lo_phase_t'(p + 2'd1);
    endfunction

    // Effective phase for this cycle, with sync overriding the stored state.
    always_comb begin
        phase   = sync ? PH_0 : state;
        cos_val = lo_cos(phase);
        sin_val = lo_sin(phase);
    end

    // Phase register: step past the phase just used, or park at PH_0 on a bare sync.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= PH_0;
        else if (advance)
            state <= step(phase);
        else if (sync)
            state <= PH_0;
    end

endmodule

// File: rtl/iq_modulation.sv
// fs/4 IQ up-rotator: baseband I/Q -> IF I/Q with a one-register output stage.
// Optional build macro MOD_SAT_EN: when defined, negating the most-negative
// sample saturates to the most-positive value instead of wrapping.
module iq_modulation
    import iq_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEFAULT,
    parameter bit PHASE_DIR = 1'b0
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     bb_rdy,
    input  logic signed [DATA_W-1:0] I_BB,
    input  logic signed [DATA_W-1:0] Q_BB,
    input  logic                     lo_sync,
    output logic signed [DATA_W-1:0] I_IF,
    output logic signed [DATA_W-1:0] Q_IF,
    output logic signed [1:0]        cosine_out,
    output logic signed [1:0]        sine_out,
    output logic                     mod_rdy
);

    lo_phase_t               phase;
    logic signed [1:0]       lo_c;
    logic signed [1:0]       lo_s;
    logic signed [DATA_W-1:0] i_nxt;
    logic signed [DATA_W-1:0] q_nxt;

    lo_phase_gen #(.PHASE_DIR(PHASE_DIR)) u_lo (
        .clk     (clk),
        .resetn  (resetn),
        .advance (bb_rdy),
        .sync    (lo_sync),
        .phase   (phase),
        .cos_val (lo_c),
        .sin_val (lo_s)
    );

`ifdef MOD_SAT_EN
    localparam logic signed [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W-1:0] S_MAX = {1'b0, {(DATA_W-1){1'b1}}};

    function automatic logic signed [DATA_W-1:0] neg(input logic signed [DATA_W-1:0] x);
        if (x == S_MIN)
            return S_MAX;
        return -x;
    endfunction
`else
    function automatic logic signed [DATA_W-1:0] neg(input logic signed [DATA_W-1:0] x);
        return -x;
    endfunction
`endif

    // LO values are only 0/+-1, so the rotation reduces to swap/negate per phase.
    always_comb begin
        i_nxt = I_BB;
        q_nxt = Q_BB;
        case (phase)
            PH_0: begin
                i_nxt = I_BB;
                q_nxt = Q_BB;
            end
            PH_90: begin
                i_nxt = Q_BB;
                q_nxt = neg(I_BB);
            end
            PH_180: begin
                i_nxt = neg(I_BB);
                q_nxt = neg(Q_BB);
            end
            PH_270: begin
                i_nxt = neg(Q_BB);
                q_nxt = I_BB;
            end
            default: begin
                i_nxt = I_BB;
                q_nxt = Q_BB;
            end
        endcase
    end

    // Output stage: data and LO tag update together on accepted samples, hold otherwise.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            I_IF       <= '0;
            Q_IF       <= '0;
            cosine_out <= LO_POS;
            sine_out   <= LO_ZERO;
            mod_rdy    <= 1'b0;
        end else begin
            mod_rdy <= bb_rdy;
            if (bb_rdy) begin
                I_IF       <= i_nxt;
                Q_IF       <= q_nxt;
                cosine_out <= lo_c;
                sine_out   <= lo_s;
            end
        end
    end

endmodule

// File: tb/tb_iq_modulation.sv
// Scoreboard bench for iq_modulation: two instances (PHASE_DIR=0 and 1) share
// stimulus; a complex-rotation reference model predicts each output sample.
module tb_iq_modulation;

    localparam int W = 5;

    typedef struct packed {
        logic signed [W-1:0] i;
        logic signed [W-1:0] q;
        logic signed [1:0]   c;
        logic signed [1:0]   s;
    } exp_t;

    localparam exp_t RST_EXP = {5'sd0, 5'sd0, 2'sb01, 2'sb00};

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic bb_rdy = 1'b0;
    logic lo_sync = 1'b0;
    logic signed [W-1:0] i_bb = '0;
    logic signed [W-1:0] q_bb = '0;

    logic signed [W-1:0] i_if0, q_if0, i_if1, q_if1;
    logic signed [1:0]   c0, s0, c1, s1;
    logic                rdy0, rdy1;
    exp_t                act0, act1;

    assign act0 = {i_if0, q_if0, c0, s0};
    assign act1 = {i_if1, q_if1, c1, s1};

    iq_modulation #(.DATA_W(W), .PHASE_DIR(1'b0)) dut0 (
        .clk(clk), .resetn(resetn), .bb_rdy(bb_rdy), .I_BB(i_bb), .Q_BB(q_bb),
        .lo_sync(lo_sync), .I_IF(i_if0), .Q_IF(q_if0), .cosine_out(c0),
        .sine_out(s0), .mod_rdy(rdy0)
    );

    iq_modulation #(.DATA_W(W), .PHASE_DIR(1'b1)) dut1 (
        .clk(clk), .resetn(resetn), .bb_rdy(bb_rdy), .I_BB(i_bb), .Q_BB(q_bb),
        .lo_sync(lo_sync), .I_IF(i_if1), .Q_IF(q_if1), .cosine_out(c1),
        .sine_out(s1), .mod_rdy(rdy1)
    );

    always #5 clk = ~clk;

    int   n_chk = 0;
    int   n_pass = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t last0 = RST_EXP;
    exp_t last1 = RST_EXP;
    int   k0 = 0;
    int   k1 = 0;
    logic prev_rdy = 1'b0;

    function automatic logic signed [W-1:0] fold(input int v);
        int t;
        t = v;
`ifdef MOD_SAT_EN
        if (t > 15)  t = 15;
        if (t < -16) t = -16;
`endif
        return t[W-1:0];
    endfunction

    // Rotation by exp(+j*k*90deg) conjugate: I' = I*cos + Q*sin, Q' = Q*cos - I*sin.
    function automatic exp_t model(input int i, input int q, input int k);
        int   kk, c, s;
        exp_t e;
        kk = ((k % 4) + 4) % 4;
        c = (kk == 0) ? 1 : (kk == 2) ? -1 : 0;
        s = (kk == 1) ? 1 : (kk == 3) ? -1 : 0;
        e.i = fold(i * c + q * s);
        e.q = fold(q * c - i * s);
        e.c = 2'(c);
        e.s = 2'(s);
        return e;
    endfunction

    task automatic check(input string name, input exp_t act, input exp_t exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s @%0t: got I=%0d Q=%0d cos=%0d sin=%0d, want I=%0d Q=%0d cos=%0d sin=%0d",
                     name, $time, act.i, act.q, act.c, act.s, exp.i, exp.q, exp.c, exp.s);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s @%0t: got %0d, want %0d", name, $time, act, exp);
    endtask

    always @(posedge clk) prev_rdy <= resetn & bb_rdy;

    // Monitor: pop one expectation per mod_rdy strobe, otherwise outputs must hold.
    always @(negedge clk) begin
        if (resetn) begin
            check_int("mod_rdy0", int'(rdy0), int'(prev_rdy));
            check_int("mod_rdy1", int'(rdy1), int'(prev_rdy));
            if (rdy0) begin
                if (q0.size() == 0) check_int("underflow0", 0, 1);
                else begin last0 = q0.pop_front(); check("data0", act0, last0); end
            end else check("hold0", act0, last0);
            if (rdy1) begin
                if (q1.size() == 0) check_int("underflow1", 0, 1);
                else begin last1 = q1.pop_front(); check("data1", act1, last1); end
            end else check("hold1", act1, last1);
        end
    end

    task automatic drive(input logic rdy, input int i, input int q, input logic sync);
        @(posedge clk);
        #2;
        bb_rdy  = rdy;
        lo_sync = sync;
        i_bb    = W'(i);
        q_bb    = W'(q);
        if (sync) begin
            k0 = 0;
            k1 = 0;
        end
        if (rdy) begin
            q0.push_back(model(i, q, k0));
            q1.push_back(model(i, q, k1));
            k0 = k0 + 1;
            k1 = k1 - 1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        bb_rdy  = 1'b0;
        lo_sync = 1'b0;
        resetn  = 1'b0;
        q0.delete();
        q1.delete();
        k0 = 0;
        k1 = 0;
        last0 = RST_EXP;
        last1 = RST_EXP;
        #1;
        check("reset0", act0, RST_EXP);
        check("reset1", act1, RST_EXP);
        check_int("reset_rdy", int'(rdy0 | rdy1), 0);
        repeat (2) @(posedge clk);
        #3 resetn = 1'b1;
    endtask

    initial begin
        do_reset();

        // Continuous stream, constant sample: full LO cycle plus wrap.
        repeat (5) drive(1'b1, 5, -3, 1'b0);

        // Three-cycle gap: phase and outputs hold, inputs change meanwhile.
        drive(1'b1, 5, -3, 1'b0);
        repeat (3) drive(1'b0, 7, 7, 1'b0);
        drive(1'b1, 5, -3, 1'b0);

        // lo_sync with a sample while in PH_180.
        do_reset();
        repeat (2) drive(1'b1, 1, 2, 1'b0);
        drive(1'b1, 5, -3, 1'b1);
        drive(1'b1, 5, -3, 1'b0);

        // lo_sync without a sample, then a sample.
        drive(1'b0, 0, 0, 1'b1);
        drive(1'b1, 4, -7, 1'b0);

        // Most-negative input negated at PH_180.
        do_reset();
        repeat (2) drive(1'b1, 3, -2, 1'b0);
        drive(1'b1, -16, 0, 1'b0);
        drive(1'b1, 0, -16, 1'b0);
        drive(1'b1, -16, -16, 1'b0);

        // Randomised traffic with a reset in the middle.
        for (int n = 0; n < 400; n++) begin
            if (n == 200) do_reset();
            drive(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                  int'($urandom_range(0, 31)) - 16,
                  int'($urandom_range(0, 31)) - 16,
                  ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0);
        end

        repeat (3) drive(1'b0, 0, 0, 1'b0);
        @(posedge clk);
        #2;
        check_int("drain0", q0.size(), 0);
        check_int("drain1", q1.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
